// File: rtl/gonso_wb_master.sv
// gonso_wb_master: single-outstanding Wishbone classic master.
// Command in, one bus cycle with ack/timeout, response out.
module gonso_wb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;

    // Handshakes and bus strobes decode straight from the state register,
    // so stb can never appear without cyc.
    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign wbm_cyc_o = (state == S_BUS);
    assign wbm_stb_o = (state == S_BUS);

    // Transaction FSM with request latch, wait counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
            wbm_sel_o <= 4'h0;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_addr;
                        wbm_dat_o <= cmd_data;
                        wbm_sel_o <= cmd_sel;
                        wait_cnt  <= 8'd0;
                        state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (wbm_ack_i) begin
                        rsp_data <= wbm_we_o ? 32'h0 : wbm_dat_i;
                        rsp_err  <= 1'b0;
                        state    <= S_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_data <= 32'h0;
                        rsp_err  <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
